wb_sel_reg: RTL and testbench



---
 rtl/cpu_pkg.sv | 25 ++
 rtl/load_ext.sv | 54 +++++
 rtl/wb_sel_reg.sv | 106 ++++++++++
 tb/tb_wb_sel_reg.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU decode encodings for the write-back select and load-extension logic.
// Latency: none (constants only).
// Backpressure: not applicable.
package cpu_pkg;

   // Destination register select (regDst)
   localparam logic [1:0] RD_RT   = 2'b00;
   localparam logic [1:0] RD_RD   = 2'b01;
   localparam logic [1:0] RD_LINK = 2'b10;
   localparam logic [1:0] RD_NONE = 2'b11;

   // Write-data source select (memToR)
   localparam logic [1:0] WD_ALU  = 2'b00;
   localparam logic [1:0] WD_MEM  = 2'b01;
   localparam logic [1:0] WD_LUI  = 2'b10;
   localparam logic [1:0] WD_LINK = 2'b11;

   // Load type (ldType); unlisted codes behave as a word load
   localparam logic [2:0] LD_W  = 3'b000;
   localparam logic [2:0] LD_B  = 3'b001;
   localparam logic [2:0] LD_BU = 3'b010;
   localparam logic [2:0] LD_H  = 3'b011;
   localparam logic [2:0] LD_HU = 3'b100;

endpackage

// File: rtl/load_ext.sv
// Load sub-word extraction and sign/zero extension of a raw memory word.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module load_ext
   import cpu_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic [DW-1:0] mem_rd_i,
   input  logic [1:0]    addr_i,
   input  logic [2:0]    ld_type_i,
   output logic [DW-1:0] ext_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Pick the addressed byte and half-word out of the low 32 bits; addr[0] is ignored for halves
   always_comb begin
      byte_sel = mem_rd_i[7:0];
      case (addr_i)
         2'd0:    byte_sel = mem_rd_i[7:0];
         2'd1:    byte_sel = mem_rd_i[15:8];
         2'd2:    byte_sel = mem_rd_i[23:16];
         default: byte_sel = mem_rd_i[31:24];
      endcase
      half_sel = addr_i[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
   end

   // Extend the selected field to DW; word loads zero any bits above 32
   always_comb begin
      ext_o = '0;
      case (ld_type_i)
         LD_B: begin
            ext_o       = {DW{byte_sel[7]}};
            ext_o[7:0]  = byte_sel;
         end
         LD_BU: begin
            ext_o[7:0]  = byte_sel;
         end
         LD_H: begin
            ext_o       = {DW{half_sel[15]}};
            ext_o[15:0] = half_sel;
         end
         LD_HU: begin
            ext_o[15:0] = half_sel;
         end
         default: begin
            ext_o[31:0] = mem_rd_i[31:0];
         end
      endcase
   end

endmodule

// File: rtl/wb_sel_reg.sv
// MEM/WB pipeline register: selects write-back destination and data, registers them for WB.
// Latency: 1 cycle from m_* inputs to w_* outputs; outputs also feed forwarding.
// Backpressure: stall holds every register, flush loads a bubble (flush beats stall).
module wb_sel_reg
   import cpu_pkg::*;
#(
   parameter int DW          = 32,
   parameter int AW          = 5,
   parameter int LINK_REG    = 31,
   parameter int PC_LINK_OFS = 8
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          stall,
   input  logic          flush,
   input  logic          m_valid,
   input  logic [DW-1:0] m_pc,
   input  logic [DW-1:0] m_alu_r,
   input  logic [DW-1:0] m_mem_rd,
   input  logic [15:0]   m_imm16,
   input  logic [AW-1:0] m_rt,
   input  logic [AW-1:0] m_rd,
   input  logic [1:0]    m_regDst,
   input  logic [1:0]    m_memToR,
   input  logic [2:0]    m_ldType,
   input  logic          m_regWrite,
   output logic          w_valid,
   output logic          w_we,
   output logic [AW-1:0] w_A3,
   output logic [DW-1:0] w_WD,
   output logic [DW-1:0] w_pc
);

   logic          valid_q, valid_d;
   logic          we_q,    we_d;
   logic [AW-1:0] a3_q,    a3_d;
   logic [DW-1:0] wd_q,    wd_d;
   logic [DW-1:0] pc_q,    pc_d;
   logic [DW-1:0] ld_data;

   load_ext #(.DW(DW)) u_load_ext (
      .mem_rd_i  (m_mem_rd),
      .addr_i    (m_alu_r[1:0]),
      .ld_type_i (m_ldType),
      .ext_o     (ld_data)
   );

   // Destination select; "none" maps to $0 so the write is suppressed below
   always_comb begin
      a3_d = '0;
      case (m_regDst)
         RD_RT:   a3_d = m_rt;
         RD_RD:   a3_d = m_rd;
         RD_LINK: a3_d = AW'(LINK_REG);
         default: a3_d = '0;
      endcase
   end

   // Write-data select; the link value wraps silently at the top of the address space
   always_comb begin
      wd_d = '0;
      case (m_memToR)
         WD_ALU:  wd_d = m_alu_r;
         WD_MEM:  wd_d = ld_data;
         WD_LUI:  wd_d[31:16] = m_imm16;
         default: wd_d = m_pc + DW'(PC_LINK_OFS);
      endcase
   end

   // Writes to $0 never reach the register file; data is still captured
   always_comb begin
      valid_d = m_valid;
      pc_d    = m_pc;
      we_d    = m_valid & m_regWrite & (a3_d != '0);
   end

   // Pipeline register: reset, then flush, then stall, then load
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= 1'b0;
         we_q    <= 1'b0;
         a3_q    <= '0;
         wd_q    <= '0;
         pc_q    <= '0;
      end else if (flush) begin
         valid_q <= 1'b0;
         we_q    <= 1'b0;
         a3_q    <= '0;
         wd_q    <= '0;
         pc_q    <= '0;
      end else if (!stall) begin
         valid_q <= valid_d;
         we_q    <= we_d;
         a3_q    <= a3_d;
         wd_q    <= wd_d;
         pc_q    <= pc_d;
      end
   end

   assign w_valid = valid_q;
   assign w_we    = we_q;
   assign w_A3    = a3_q;
   assign w_WD    = wd_q;
   assign w_pc    = pc_q;

endmodule

// File: tb/tb_wb_sel_reg.sv
// Directed bench for wb_sel_reg: 32-bit default instance plus a 64-bit/6-bit-address instance.
// Latency: checks sample 1 time unit after each rising edge.
// Backpressure: stall/flush exercised on the 32-bit instance only.
module tb_wb_sel_reg;
   import cpu_pkg::*;

   int nvec = 0;
   int nerr = 0;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        stall = 1'b0;
   logic        flush = 1'b0;

   // 32-bit instance signals
   logic        m_valid = 1'b0;
   logic [31:0] m_pc = '0, m_alu_r = '0, m_mem_rd = '0;
   logic [15:0] m_imm16 = '0;
   logic [4:0]  m_rt = '0, m_rd = '0;
   logic [1:0]  m_regDst = '0, m_memToR = '0;
   logic [2:0]  m_ldType = '0;
   logic        m_regWrite = 1'b0;
   logic        w_valid, w_we;
   logic [4:0]  w_A3;
   logic [31:0] w_WD, w_pc;

   // 64-bit instance signals
   logic        x_valid = 1'b0;
   logic [63:0] x_pc = '0, x_alu_r = '0, x_mem_rd = '0;
   logic [15:0] x_imm16 = '0;
   logic [5:0]  x_rt = '0, x_rd = '0;
   logic [1:0]  x_regDst = '0, x_memToR = '0;
   logic [2:0]  x_ldType = '0;
   logic        x_regWrite = 1'b0;
   logic        xw_valid, xw_we;
   logic [5:0]  xw_A3;
   logic [63:0] xw_WD, xw_pc;

   always #5 clk = ~clk;

   wb_sel_reg dut (
      .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush),
      .m_valid(m_valid), .m_pc(m_pc), .m_alu_r(m_alu_r), .m_mem_rd(m_mem_rd),
      .m_imm16(m_imm16), .m_rt(m_rt), .m_rd(m_rd), .m_regDst(m_regDst),
      .m_memToR(m_memToR), .m_ldType(m_ldType), .m_regWrite(m_regWrite),
      .w_valid(w_valid), .w_we(w_we), .w_A3(w_A3), .w_WD(w_WD), .w_pc(w_pc)
   );

   wb_sel_reg #(.DW(64), .AW(6), .LINK_REG(63), .PC_LINK_OFS(8)) dut64 (
      .clk(clk), .reset_n(reset_n), .stall(1'b0), .flush(1'b0),
      .m_valid(x_valid), .m_pc(x_pc), .m_alu_r(x_alu_r), .m_mem_rd(x_mem_rd),
      .m_imm16(x_imm16), .m_rt(x_rt), .m_rd(x_rd), .m_regDst(x_regDst),
      .m_memToR(x_memToR), .m_ldType(x_ldType), .m_regWrite(x_regWrite),
      .w_valid(xw_valid), .w_we(xw_we), .w_A3(xw_A3), .w_WD(xw_WD), .w_pc(xw_pc)
   );

   // Drive one MEM-stage instruction onto the 32-bit instance
   task automatic drive(input logic v, input logic rw, input logic [1:0] rdst, input logic [1:0] m2r,
                        input logic [2:0] lt, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] mem,
                        input logic [15:0] imm);
      m_valid = v; m_regWrite = rw; m_regDst = rdst; m_memToR = m2r; m_ldType = lt;
      m_rt = rt; m_rd = rd; m_pc = pc; m_alu_r = alu; m_mem_rd = mem; m_imm16 = imm;
   endtask

   task automatic test_reset();
      #1 reset_n = 1'b0;
      #10;
      nvec++; if (w_valid !== 1'b0) begin nerr++; $display("FAIL rst0_valid: got %b want 0", w_valid); end
      reset_n = 1'b1;
      // Load a non-zero entry, then reset asynchronously in mid-cycle
      @(negedge clk); drive(1, 1, RD_RD, WD_ALU, LD_W, 5'd0, 5'd7, 32'h100, 32'h55, 32'h0, 16'h0);
      @(posedge clk); #1;
      nvec++; if (w_A3 !== 5'd7 || w_WD !== 32'h55 || w_we !== 1'b1) begin nerr++; $display("FAIL pre_rst_rd: got a3=%0d wd=%h we=%b want 7 00000055 1", w_A3, w_WD, w_we); end
      @(negedge clk); #2 reset_n = 1'b0; #1;
      nvec++; if (w_valid !== 1'b0) begin nerr++; $display("FAIL rst_valid: got %b want 0", w_valid); end
      nvec++; if (w_we !== 1'b0) begin nerr++; $display("FAIL rst_we: got %b want 0", w_we); end
      nvec++; if (w_A3 !== 5'd0) begin nerr++; $display("FAIL rst_a3: got %0d want 0", w_A3); end
      nvec++; if (w_WD !== 32'h0) begin nerr++; $display("FAIL rst_wd: got %h want 0", w_WD); end
      nvec++; if (w_pc !== 32'h0) begin nerr++; $display("FAIL rst_pc: got %h want 0", w_pc); end
      #1 reset_n = 1'b1;
   endtask

   task automatic test_lw();
      @(negedge clk); drive(1, 1, RD_RT, WD_MEM, LD_W, 5'd5, 5'd0, 32'h400, 32'h1000, 32'h12345678, 16'h0);
      @(posedge clk); #1;
      nvec++; if (w_A3 !== 5'd5) begin nerr++; $display("FAIL lw_a3: got %0d want 5", w_A3); end
      nvec++; if (w_WD !== 32'h12345678) begin nerr++; $display("FAIL lw_wd: got %h want 12345678", w_WD); end
      nvec++; if (w_we !== 1'b1) begin nerr++; $display("FAIL lw_we: got %b want 1", w_we); end
      nvec++; if (w_valid !== 1'b1 || w_pc !== 32'h400) begin nerr++; $display("FAIL lw_vpc: got %b %h want 1 00000400", w_valid, w_pc); end
   endtask

   task automatic test_load_ext();
      logic [2:0]  lt;
      logic [1:0]  ad;
      logic [31:0] exp;
      for (int i = 0; i < 8; i++) begin
         case (i)
            0:       begin lt = LD_B;   ad = 2'd3; exp = 32'hFFFFFF80; end
            1:       begin lt = LD_BU;  ad = 2'd3; exp = 32'h00000080; end
            2:       begin lt = LD_H;   ad = 2'd1; exp = 32'h00007F01; end
            3:       begin lt = LD_HU;  ad = 2'd2; exp = 32'h000080FF; end
            4:       begin lt = LD_H;   ad = 2'd2; exp = 32'hFFFF80FF; end
            5:       begin lt = LD_B;   ad = 2'd1; exp = 32'h0000007F; end
            6:       begin lt = LD_BU;  ad = 2'd2; exp = 32'h000000FF; end
            default: begin lt = 3'b111; ad = 2'd2; exp = 32'h80FF7F01; end
         endcase
         @(negedge clk); drive(1, 1, RD_RT, WD_MEM, lt, 5'd9, 5'd0, 32'h0, {30'h10, ad}, 32'h80FF7F01, 16'h0);
         @(posedge clk); #1;
         nvec++; if (w_WD !== exp) begin nerr++; $display("FAIL ldext_%0d: got %h want %h", i, w_WD, exp); end
      end
   endtask

   task automatic test_jal();
      @(negedge clk); drive(1, 1, RD_LINK, WD_LINK, LD_W, 5'd3, 5'd4, 32'h00003000, 32'h0, 32'h0, 16'h0);
      @(posedge clk); #1;
      nvec++; if (w_A3 !== 5'd31) begin nerr++; $display("FAIL jal_a3: got %0d want 31", w_A3); end
      nvec++; if (w_WD !== 32'h00003008) begin nerr++; $display("FAIL jal_wd: got %h want 00003008", w_WD); end
      nvec++; if (w_we !== 1'b1) begin nerr++; $display("FAIL jal_we: got %b want 1", w_we); end
      @(negedge clk); drive(1, 1, RD_LINK, WD_LINK, LD_W, 5'd3, 5'd4, 32'hFFFFFFFC, 32'h0, 32'h0, 16'h0);
      @(posedge clk); #1;
      nvec++; if (w_WD !== 32'h00000004) begin nerr++; $display("FAIL jal_wrap: got %h want 00000004", w_WD); end
      // Invalid instruction must not write even with regWrite set
      @(negedge clk); drive(0, 1, RD_LINK, WD_LINK, LD_W, 5'd3, 5'd4, 32'h00003000, 32'h0, 32'h0, 16'h0);
      @(posedge clk); #1;
      nvec++; if (w_we !== 1'b0 || w_valid !== 1'b0) begin nerr++; $display("FAIL inval_we: got we=%b v=%b want 0 0", w_we, w_valid); end
   endtask

   task automatic test_lui_zero();
      @(negedge clk); drive(1, 1, RD_RT, WD_LUI, LD_W, 5'd0, 5'd6, 32'h0, 32'h0, 32'h0, 16'hABCD);
      @(posedge clk); #1;
      nvec++; if (w_WD !== 32'hABCD0000) begin nerr++; $display("FAIL lui_wd: got %h want abcd0000", w_WD); end
      nvec++; if (w_A3 !== 5'd0) begin nerr++; $display("FAIL lui_a3: got %0d want 0", w_A3); end
      nvec++; if (w_we !== 1'b0) begin nerr++; $display("FAIL lui_we0: got %b want 0", w_we); end
      @(negedge clk); drive(1, 1, RD_NONE, WD_LUI, LD_W, 5'd9, 5'd6, 32'h0, 32'h0, 32'h0, 16'hABCD);
      @(posedge clk); #1;
      nvec++; if (w_A3 !== 5'd0) begin nerr++; $display("FAIL none_a3: got %0d want 0", w_A3); end
      nvec++; if (w_we !== 1'b0) begin nerr++; $display("FAIL none_we: got %b want 0", w_we); end
   endtask

   task automatic test_stall_flush();
      @(negedge clk); drive(1, 1, RD_RD, WD_ALU, LD_W, 5'd0, 5'd3, 32'h100, 32'h11, 32'h0, 16'h0);
      @(posedge clk); #1;
      nvec++; if (w_WD !== 32'h11) begin nerr++; $display("FAIL sf_load: got %h want 00000011", w_WD); end
      @(negedge clk); drive(1, 1, RD_RD, WD_ALU, LD_W, 5'd0, 5'd4, 32'h200, 32'h22, 32'h0, 16'h0); stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         nvec++; if (w_WD !== 32'h11 || w_A3 !== 5'd3) begin nerr++; $display("FAIL stall_%0d: got wd=%h a3=%0d want 00000011 3", i, w_WD, w_A3); end
         nvec++; if (w_pc !== 32'h100 || w_valid !== 1'b1) begin nerr++; $display("FAIL stall_pc_%0d: got %h %b want 00000100 1", i, w_pc, w_valid); end
      end
      @(negedge clk); flush = 1'b1;
      @(posedge clk); #1;
      nvec++; if (w_valid !== 1'b0) begin nerr++; $display("FAIL flush_valid: got %b want 0", w_valid); end
      nvec++; if (w_we !== 1'b0) begin nerr++; $display("FAIL flush_we: got %b want 0", w_we); end
      nvec++; if (w_WD !== 32'h0) begin nerr++; $display("FAIL flush_wd: got %h want 0", w_WD); end
      nvec++; if (w_A3 !== 5'd0 || w_pc !== 32'h0) begin nerr++; $display("FAIL flush_a3pc: got %0d %h want 0 0", w_A3, w_pc); end
      @(negedge clk); stall = 1'b0; flush = 1'b0;
      @(posedge clk); #1;
      nvec++; if (w_WD !== 32'h22) begin nerr++; $display("FAIL release_wd: got %h want 00000022", w_WD); end
      nvec++; if (w_A3 !== 5'd4 || w_valid !== 1'b1 || w_we !== 1'b1) begin nerr++; $display("FAIL release_ctl: got %0d %b %b want 4 1 1", w_A3, w_valid, w_we); end
   endtask

   task automatic test_param64();
      @(negedge clk);
      x_valid = 1; x_regWrite = 1; x_regDst = RD_LINK; x_memToR = WD_LINK; x_ldType = LD_W;
      x_pc = 64'h0000_0001_0000_3000;
      @(posedge clk); #1;
      nvec++; if (xw_A3 !== 6'd63) begin nerr++; $display("FAIL p64_jal_a3: got %0d want 63", xw_A3); end
      nvec++; if (xw_WD !== 64'h0000_0001_0000_3008) begin nerr++; $display("FAIL p64_jal_wd: got %h want 0000000100003008", xw_WD); end
      @(negedge clk);
      x_regDst = RD_RT; x_rt = 6'd40; x_memToR = WD_MEM; x_ldType = LD_W;
      x_alu_r = 64'h0; x_mem_rd = 64'hDEAD_BEEF_8000_0000;
      @(posedge clk); #1;
      nvec++; if (xw_WD !== 64'h0000_0000_8000_0000) begin nerr++; $display("FAIL p64_lw: got %h want 0000000080000000", xw_WD); end
      nvec++; if (xw_A3 !== 6'd40 || xw_we !== 1'b1) begin nerr++; $display("FAIL p64_lw_ctl: got %0d %b want 40 1", xw_A3, xw_we); end
      @(negedge clk);
      x_ldType = LD_B; x_alu_r = 64'h3; x_mem_rd = 64'h0000_0000_80FF_7F01;
      @(posedge clk); #1;
      nvec++; if (xw_WD !== 64'hFFFF_FFFF_FFFF_FF80) begin nerr++; $display("FAIL p64_lb: got %h want ffffffffffffff80", xw_WD); end
   endtask

   initial begin
      test_reset();
      test_lw();
      test_load_ext();
      test_jal();
      test_lui_zero();
      test_stall_flush();
      test_param64();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
